nibble_add_checker: RTL and testbench
=====================================

Name: nibble_add_checker

Overview:
- Receiving-end checker for the registered nibble adder: byte {a,b} in, 4-bit (a+b) on result[3:0], result[7:4] held 0.
- Captures each operand byte issued to the adder and computes the expected sum.
- Samples the adder's output byte LATENCY cycles later, compares, and keeps pass/fail statistics.
- Captures the first failing transaction for debug.
- Sits beside the adder in self-test builds; fully pipelined, one transaction per cycle.

Parameters:
LATENCY, 1, cycles from operand issue to valid adder output; legal range 1..8
CNT_W, 8, width of transaction and error counters

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand byte issued to adder this cycle
in_operands  input  8  operand byte; a=[7:4], b=[3:0]
dut_result  input  8  adder output byte, sampled LATENCY cycles after issue
clear  input  1  synchronous clear of statistics
chk_valid  output  1  one-cycle pulse: a comparison completed
chk_pass  output  1  result of that comparison; meaningful only with chk_valid
expected  output  4  expected sum for the reported comparison
total_cnt  output  CNT_W  comparisons performed, saturating
err_cnt  output  CNT_W  failed comparisons, saturating
err_sticky  output  1  set on any failure until clear/reset
first_err_operands  output  8  operand byte of first failure since clear/reset
first_err_result  output  8  dut_result of first failure
busy  output  1  any pipeline stage holds a valid transaction

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset. Reset overrides clear and in_valid.
- Reset: all outputs 0, all pipeline valids 0. Reset mid-stream drops in-flight transactions; no chk_valid for them.
- Expected value: (a+b) mod 16, carry dropped, computed at capture.
- Delay line:
  - LATENCY stages, each holding {valid, operands, expected}.
  - Stage 0 loads in_valid/in_operands every cycle.
  - Stage LATENCY-1 is the tail.
- Compare: when the tail is valid, dut_result is sampled that cycle. Pass iff dut_result[3:0]==expected and dut_result[7:4]==0.
- Report timing: an operand issued in cycle t is sampled at t+LATENCY. On the following edge, chk_valid/chk_pass/expected are updated, visible in cycle t+LATENCY+1.
  - chk_valid low otherwise.
  - expected/chk_pass hold their last values while chk_valid is low.
- Counters:
  - total_cnt +1 per comparison; err_cnt +1 per failure.
  - Both saturate at 2^CNT_W-1, no wrap.
- Sticky/capture:
  - err_sticky is set on the first failure.
  - first_err_operands/first_err_result load only while err_sticky is 0, so later failures do not overwrite.
- clear:
  - Zeroes total_cnt, err_cnt, err_sticky, first_err_*.
  - A comparison in the same cycle is still reported on chk_valid/chk_pass but not counted or captured (clear wins).
  - The pipeline is not flushed.
- busy: OR of stage valids. Low when idle.
- Back-to-back: in_valid may be high every cycle; no stall, no backpressure.
- Gaps in in_valid produce matching gaps in chk_valid.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1 -> all outputs 0, busy=0; no chk_valid in the LATENCY+1 cycles after release.
- Single pass, LATENCY=1: in_operands=0x35 in cycle t, dut_result=0x08 in t+1 -> in t+2: chk_valid=1, chk_pass=1, expected=0x8, total_cnt=1, err_cnt=0.
- Carry and upper nibble: 0xF3 -> expected=0x2.
  - dut 0x02 -> pass.
  - Next 0xF3 with dut 0x12 -> fail, err_cnt=1, err_sticky=1, first_err_operands=0xF3, first_err_result=0x12.
- Streaming, LATENCY=3: 0x11, 0x22, 0x34 on consecutive cycles; dut returns 0x02, 0x05, 0x07 -> three consecutive chk_valid with pass/fail/pass.
  - first_err captures 0x22/0x05.
  - A later failing 0x11 with dut 0x00 leaves the capture unchanged and sets err_cnt=2.
- Saturation, CNT_W=4: 20 failing transactions -> total_cnt=15, err_cnt=15.
- clear and reset races:
  - clear asserted in the report cycle of a failure -> chk_valid=1, chk_pass=0, but err_cnt=0 and err_sticky=0 afterward.
  - reset asserted with 2 transactions in flight -> no chk_valid after, busy=0.

Source files
------------

// File: rtl/nibble_add_checker.sv
// Receive-side checker for the registered nibble adder: tracks each issued operand
// byte through a LATENCY-deep delay line, compares the adder output and keeps statistics.
module nibble_add_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_operands,
  input  logic [7:0]       dut_result,
  input  logic             clear,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [3:0]       expected,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic [7:0]       first_err_operands,
  output logic [7:0]       first_err_result,
  output logic             busy
);

  logic [LATENCY-1:0] stg_valid;
  logic [7:0]         stg_ops [LATENCY];
  logic [3:0]         stg_exp [LATENCY];

  logic       tail_valid;
  logic [7:0] tail_ops;
  logic [3:0] tail_exp;
  logic       cmp_pass;

  assign tail_valid = stg_valid[LATENCY-1];
  assign tail_ops   = stg_ops[LATENCY-1];
  assign tail_exp   = stg_exp[LATENCY-1];
  // Upper nibble of the adder output must stay zero for a pass.
  assign cmp_pass   = (dut_result == {4'h0, tail_exp});
  assign busy       = |stg_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_ops[i] <= '0;
        stg_exp[i] <= '0;
      end
    end else begin
      stg_valid[0] <= in_valid;
      stg_ops[0]   <= in_operands;
      stg_exp[0]   <= in_operands[7:4] + in_operands[3:0];
      for (int i = 1; i < LATENCY; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_ops[i]   <= stg_ops[i-1];
        stg_exp[i]   <= stg_exp[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_valid          <= 1'b0;
      chk_pass           <= 1'b0;
      expected           <= '0;
      total_cnt          <= '0;
      err_cnt            <= '0;
      err_sticky         <= 1'b0;
      first_err_operands <= '0;
      first_err_result   <= '0;
    end else begin
      chk_valid <= tail_valid;
      if (tail_valid) begin
        chk_pass <= cmp_pass;
        expected <= tail_exp;
      end
      // clear beats a same-cycle comparison: it is reported but not counted.
      if (clear) begin
        total_cnt          <= '0;
        err_cnt            <= '0;
        err_sticky         <= 1'b0;
        first_err_operands <= '0;
        first_err_result   <= '0;
      end else if (tail_valid) begin
        if (total_cnt != {CNT_W{1'b1}})
          total_cnt <= total_cnt + 1'b1;
        if (!cmp_pass) begin
          if (err_cnt != {CNT_W{1'b1}})
            err_cnt <= err_cnt + 1'b1;
          if (!err_sticky) begin
            err_sticky         <= 1'b1;
            first_err_operands <= tail_ops;
            first_err_result   <= dut_result;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_add_checker.sv
// Scoreboard bench for nibble_add_checker: one instance at LATENCY=1/CNT_W=8 and
// one at LATENCY=3/CNT_W=4, each fed by a small adder emulator with chosen responses.
module tb_nibble_add_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance A: LATENCY=1, CNT_W=8
  logic       a_reset, a_in_valid, a_clear;
  logic [7:0] a_ops, a_resp, a_result;
  logic       a_chk_valid, a_chk_pass, a_sticky, a_busy;
  logic [3:0] a_expected;
  logic [7:0] a_total, a_err, a_fe_ops, a_fe_res;

  // instance B: LATENCY=3, CNT_W=4
  logic       b_reset, b_in_valid, b_clear;
  logic [7:0] b_ops, b_resp, b_result;
  logic       b_chk_valid, b_chk_pass, b_sticky, b_busy;
  logic [3:0] b_expected;
  logic [3:0] b_total, b_err;
  logic [7:0] b_fe_ops, b_fe_res;
  logic [7:0] b_p0, b_p1;

  logic [4:0] qa[$];
  logic [4:0] qb[$];

  nibble_add_checker #(.LATENCY(1), .CNT_W(8)) u_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_operands(a_ops),
    .dut_result(a_result), .clear(a_clear), .chk_valid(a_chk_valid),
    .chk_pass(a_chk_pass), .expected(a_expected), .total_cnt(a_total),
    .err_cnt(a_err), .err_sticky(a_sticky), .first_err_operands(a_fe_ops),
    .first_err_result(a_fe_res), .busy(a_busy)
  );

  nibble_add_checker #(.LATENCY(3), .CNT_W(4)) u_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_operands(b_ops),
    .dut_result(b_result), .clear(b_clear), .chk_valid(b_chk_valid),
    .chk_pass(b_chk_pass), .expected(b_expected), .total_cnt(b_total),
    .err_cnt(b_err), .err_sticky(b_sticky), .first_err_operands(b_fe_ops),
    .first_err_result(b_fe_res), .busy(b_busy)
  );

  // Adder emulators: the chosen response appears LATENCY cycles after issue.
  always @(posedge clk) a_result <= a_resp;
  always @(posedge clk) begin
    b_p0     <= b_resp;
    b_p1     <= b_p0;
    b_result <= b_p1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expected {pass, sum} per reported comparison.
  always @(negedge clk) begin
    logic [4:0] e;
    if (a_chk_valid) begin
      if (qa.size() == 0) begin
        check("A unexpected chk_valid", 32'(a_chk_valid), 32'd0);
      end else begin
        e = qa.pop_front();
        check("A chk_pass", 32'(a_chk_pass), 32'(e[4]));
        check("A expected", 32'(a_expected), 32'(e[3:0]));
      end
    end
    if (b_chk_valid) begin
      if (qb.size() == 0) begin
        check("B unexpected chk_valid", 32'(b_chk_valid), 32'd0);
      end else begin
        e = qb.pop_front();
        check("B chk_pass", 32'(b_chk_pass), 32'(e[4]));
        check("B expected", 32'(b_expected), 32'(e[3:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input bit sel_b, input logic [7:0] ops, input logic [7:0] resp,
                       input logic [3:0] ex, input logic ps);
    if (!sel_b) begin
      a_in_valid = 1'b1; a_ops = ops; a_resp = resp; qa.push_back({ps, ex});
    end else begin
      b_in_valid = 1'b1; b_ops = ops; b_resp = resp; qb.push_back({ps, ex});
    end
    tick();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  initial begin
    a_reset = 1'b1; a_in_valid = 1'b1; a_clear = 1'b0; a_ops = 8'h35; a_resp = 8'h00;
    b_reset = 1'b1; b_in_valid = 1'b1; b_clear = 1'b0; b_ops = 8'h35; b_resp = 8'h00;
    tick();
    tick();

    // Reset state with in_valid held high
    check("A reset chk_valid", 32'(a_chk_valid), 32'd0);
    check("A reset chk_pass", 32'(a_chk_pass), 32'd0);
    check("A reset expected", 32'(a_expected), 32'd0);
    check("A reset total", 32'(a_total), 32'd0);
    check("A reset err", 32'(a_err), 32'd0);
    check("A reset sticky", 32'(a_sticky), 32'd0);
    check("A reset fe_ops", 32'(a_fe_ops), 32'd0);
    check("A reset fe_res", 32'(a_fe_res), 32'd0);
    check("A reset busy", 32'(a_busy), 32'd0);
    check("B reset busy", 32'(b_busy), 32'd0);
    check("B reset total", 32'(b_total), 32'd0);

    a_reset = 1'b0; a_in_valid = 1'b0;
    repeat (2) begin
      tick();
      check("A no chk after reset", 32'(a_chk_valid), 32'd0);
    end

    // Instance A: single pass, carry, upper-nibble failure
    issue(1'b0, 8'h35, 8'h08, 4'h8, 1'b1);
    check("A busy in flight", 32'(a_busy), 32'd1);
    tick();
    check("A total after 1", 32'(a_total), 32'd1);
    check("A err after 1", 32'(a_err), 32'd0);
    issue(1'b0, 8'hF3, 8'h02, 4'h2, 1'b1);
    issue(1'b0, 8'hF3, 8'h12, 4'h2, 1'b0);
    idle(2);
    check("A total after 3", 32'(a_total), 32'd3);
    check("A err after 3", 32'(a_err), 32'd1);
    check("A sticky", 32'(a_sticky), 32'd1);
    check("A fe_ops", 32'(a_fe_ops), 32'hF3);
    check("A fe_res", 32'(a_fe_res), 32'h12);
    check("A idle busy", 32'(a_busy), 32'd0);

    // Gap in in_valid
    issue(1'b0, 8'h9A, 8'h03, 4'h3, 1'b1);
    idle(1);
    issue(1'b0, 8'h44, 8'h08, 4'h8, 1'b1);
    idle(2);
    check("A total after gap", 32'(a_total), 32'd5);

    // clear asserted in the compare cycle of a failure
    issue(1'b0, 8'h12, 8'h00, 4'h3, 1'b0);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check("A clear err", 32'(a_err), 32'd0);
    check("A clear total", 32'(a_total), 32'd0);
    check("A clear sticky", 32'(a_sticky), 32'd0);
    check("A clear fe_ops", 32'(a_fe_ops), 32'd0);
    check("A clear fe_res", 32'(a_fe_res), 32'd0);
    issue(1'b0, 8'h35, 8'h08, 4'h8, 1'b1);
    tick();
    check("A total after clear", 32'(a_total), 32'd1);

    // Instance B: streaming at LATENCY=3
    b_reset = 1'b0; b_in_valid = 1'b0;
    tick();
    issue(1'b1, 8'h11, 8'h02, 4'h2, 1'b1);
    check("B busy in flight", 32'(b_busy), 32'd1);
    issue(1'b1, 8'h22, 8'h05, 4'h4, 1'b0);
    issue(1'b1, 8'h34, 8'h07, 4'h7, 1'b1);
    idle(4);
    check("B total after 3", 32'(b_total), 32'd3);
    check("B err after 3", 32'(b_err), 32'd1);
    check("B sticky", 32'(b_sticky), 32'd1);
    check("B fe_ops", 32'(b_fe_ops), 32'h22);
    check("B fe_res", 32'(b_fe_res), 32'h05);
    issue(1'b1, 8'h11, 8'h00, 4'h2, 1'b0);
    idle(4);
    check("B err after 4", 32'(b_err), 32'd2);
    check("B fe_ops kept", 32'(b_fe_ops), 32'h22);
    check("B fe_res kept", 32'(b_fe_res), 32'h05);

    // Saturation at 4-bit counters
    repeat (20) issue(1'b1, 8'h00, 8'hFF, 4'h0, 1'b0);
    idle(4);
    check("B total sat", 32'(b_total), 32'd15);
    check("B err sat", 32'(b_err), 32'd15);

    // Reset with two transactions in flight
    issue(1'b1, 8'h56, 8'h0B, 4'hB, 1'b1);
    issue(1'b1, 8'h78, 8'h0F, 4'hF, 1'b1);
    b_reset = 1'b1;
    qb.delete();
    tick();
    b_reset = 1'b0;
    repeat (5) begin
      tick();
      check("B no chk after reset", 32'(b_chk_valid), 32'd0);
      check("B busy after reset", 32'(b_busy), 32'd0);
    end
    check("B total after reset", 32'(b_total), 32'd0);

    idle(2);
    check("A queue drained", 32'(qa.size()), 32'd0);
    check("B queue drained", 32'(qb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
